// File: rtl/mem_port_arbiter.sv
// Arbitrates a fixed-latency memory port between fetch and data requesters; data wins ties.
// Ready arrives LATENCY cycles after the request is seen idle; requesters stall until then.
module mem_port_arbiter #(
   parameter int LATENCY = 2,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              IReq,
   input  logic [ADDR_W-1:0] IAddr,
   output logic              IReady,
   output logic [DATA_W-1:0] IRdata,
   input  logic              DReq,
   input  logic              DWe,
   input  logic [ADDR_W-1:0] DAddr,
   input  logic [DATA_W-1:0] DWdata,
   output logic              DReady,
   output logic [DATA_W-1:0] DRdata,
   output logic [ADDR_W-1:0] MemAddr,
   output logic              MemWe,
   output logic [DATA_W-1:0] MemWdata,
   input  logic [DATA_W-1:0] MemRdata,
   output logic              StallIF,
   output logic              StallMem,
   output logic              Busy
);

   localparam int CW = $clog2(LATENCY) + 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          we_r;
   logic          done;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         MemAddr  <= '0;
         MemWdata <= '0;
         we_r     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (DReq) begin
                  state    <= BUSY_D;
                  MemAddr  <= DAddr;
                  MemWdata <= DWdata;
                  we_r     <= DWe;
                  cnt      <= CNT_INIT;
               end else if (IReq) begin
                  state   <= BUSY_I;
                  MemAddr <= IAddr;
                  cnt     <= CNT_INIT;
               end
            end
            // Requests seen in the completion cycle belong to the finished access.
            default: begin
               if (cnt == '0) state <= IDLE;
               else           cnt   <= cnt - CW'(1);
            end
         endcase
      end
   end

   // A reset landing on the completion cycle abandons the access without a ready pulse.
   assign done     = (cnt == '0) && !rst;
   assign IReady   = (state == BUSY_I) && done;
   assign DReady   = (state == BUSY_D) && done;
   assign MemWe    = (state == BUSY_D) && we_r && done;
   assign IRdata   = IReady ? MemRdata : '0;
   assign DRdata   = DReady ? MemRdata : '0;
   assign StallIF  = IReq && !IReady;
   assign StallMem = DReq && !DReady;
   assign Busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter at LATENCY 1, 2 and 3 with a read-completion scoreboard.
module tb_mem_port_arbiter;

   typedef struct {
      bit          is_d;
      logic [31:0] data;
      int          due;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        ireq, dreq, dwe;
   logic [31:0] iaddr, daddr, dwdata;
   logic [2:0]  iready, dready, memwe, stallif, stallmem, busy;
   logic [31:0] irdata [3];
   logic [31:0] drdata [3];
   logic [31:0] memaddr [3];
   logic [31:0] memwdata [3];
   logic [31:0] memrdata [3];

   exp_t sbq[$];
   int   cyc;
   int   sel;
   int   we_cnt;
   int   total;
   int   bad;

   // Memory model: read data is a fixed scramble of the presented address.
   function automatic logic [31:0] memf(input logic [31:0] a);
      return a ^ 32'h0050_0193;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      assign memrdata[g] = memf(memaddr[g]);
      mem_port_arbiter #(.LATENCY(g + 1), .ADDR_W(32), .DATA_W(32)) u_dut (
         .clk(clk), .rst(rst),
         .IReq(ireq), .IAddr(iaddr), .IReady(iready[g]), .IRdata(irdata[g]),
         .DReq(dreq), .DWe(dwe), .DAddr(daddr), .DWdata(dwdata),
         .DReady(dready[g]), .DRdata(drdata[g]),
         .MemAddr(memaddr[g]), .MemWe(memwe[g]), .MemWdata(memwdata[g]),
         .MemRdata(memrdata[g]),
         .StallIF(stallif[g]), .StallMem(stallmem[g]), .Busy(busy[g])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #300000;
      $display("FAIL global_timeout cycle=%0d", cyc);
      $fatal(1, "bench stalled");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic sb_check();
      logic ir, dr;
      exp_t e;
      ir = iready[sel];
      dr = dready[sel];
      if (memwe[sel]) we_cnt++;
      if (ir || dr) begin
         if (sbq.size() == 0) begin
            chk("sb_unexpected_ready", {31'b0, ir | dr}, 32'd0);
         end else begin
            e = sbq.pop_front();
            chk("sb_kind", {31'b0, dr}, {31'b0, e.is_d});
            chk("sb_data", dr ? drdata[sel] : irdata[sel], e.data);
            chk("sb_cycle", cyc, e.due);
         end
      end else if (sbq.size() > 0 && cyc >= sbq[0].due) begin
         chk("sb_missing_ready", {31'b0, ir | dr}, 32'd1);
         void'(sbq.pop_front());
      end
      if (!ir) chk("irdata_not_ready", irdata[sel], 32'd0);
      if (!dr) chk("drdata_not_ready", drdata[sel], 32'd0);
   endtask

   task automatic mid();
      @(negedge clk);
      sb_check();
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         mid();
         adv();
      end
   endtask

   task automatic chk_all_zero(input int g);
      chk("zero_busy",     {31'b0, busy[g]},     32'd0);
      chk("zero_iready",   {31'b0, iready[g]},   32'd0);
      chk("zero_dready",   {31'b0, dready[g]},   32'd0);
      chk("zero_memwe",    {31'b0, memwe[g]},    32'd0);
      chk("zero_stallif",  {31'b0, stallif[g]},  32'd0);
      chk("zero_stallmem", {31'b0, stallmem[g]}, 32'd0);
      chk("zero_irdata",   irdata[g],   32'd0);
      chk("zero_drdata",   drdata[g],   32'd0);
      chk("zero_memaddr",  memaddr[g],  32'd0);
      chk("zero_memwdata", memwdata[g], 32'd0);
   endtask

   initial begin
      int t;
      total = 0; bad = 0; cyc = 0; sel = 1; we_cnt = 0;
      rst = 1'b1; ireq = 1'b0; dreq = 1'b0; dwe = 1'b0;
      iaddr = '0; daddr = '0; dwdata = '0;

      // Reset state of every instance
      mid();
      for (int g = 0; g < 3; g++) chk_all_zero(g);
      adv();
      mid();
      adv();
      rst = 1'b0;
      idle(2);

      // Single fetch at LATENCY=2
      sel = 1; we_cnt = 0;
      t = cyc;
      ireq = 1'b1; iaddr = 32'h100;
      sbq.push_back('{is_d: 1'b0, data: 32'h0050_0093, due: t + 2});
      mid();
      chk("f1_stallif_t", {31'b0, stallif[1]}, 32'd1);
      chk("f1_busy_t", {31'b0, busy[1]}, 32'd0);
      adv();
      mid();
      chk("f1_stallif_t1", {31'b0, stallif[1]}, 32'd1);
      chk("f1_busy_t1", {31'b0, busy[1]}, 32'd1);
      adv();
      mid();
      chk("f1_iready_t2", {31'b0, iready[1]}, 32'd1);
      chk("f1_irdata_t2", irdata[1], 32'h0050_0093);
      chk("f1_stallif_t2", {31'b0, stallif[1]}, 32'd0);
      adv();
      ireq = 1'b0;
      mid();
      chk("f1_busy_t3", {31'b0, busy[1]}, 32'd0);
      adv();
      idle(2);
      chk("f1_no_memwe", we_cnt, 32'd0);

      // Simultaneous fetch and load: data first
      sel = 1;
      t = cyc;
      ireq = 1'b1; iaddr = 32'h300;
      dreq = 1'b1; dwe = 1'b0; daddr = 32'h2000;
      sbq.push_back('{is_d: 1'b1, data: memf(32'h2000), due: t + 2});
      sbq.push_back('{is_d: 1'b0, data: memf(32'h300),  due: t + 5});
      for (int k = 0; k <= 5; k++) begin
         mid();
         chk("c2_stallif", {31'b0, stallif[1]}, (k == 5) ? 32'd0 : 32'd1);
         chk("c2_busy", {31'b0, busy[1]}, (k == 0 || k == 3) ? 32'd0 : 32'd1);
         if (k == 2) chk("c2_stallmem_t2", {31'b0, stallmem[1]}, 32'd0);
         if (k == 4) chk("c2_memaddr_t4", memaddr[1], 32'h300);
         adv();
         if (k == 2) dreq = 1'b0;
      end
      ireq = 1'b0;
      idle(2);

      // Store at LATENCY=3
      sel = 2; we_cnt = 0;
      t = cyc;
      dreq = 1'b1; dwe = 1'b1; daddr = 32'h40; dwdata = 32'hDEAD_BEEF;
      sbq.push_back('{is_d: 1'b1, data: memf(32'h40), due: t + 3});
      for (int k = 0; k <= 3; k++) begin
         mid();
         chk("st_memwe", {31'b0, memwe[2]}, (k == 3) ? 32'd1 : 32'd0);
         if (k == 3) begin
            chk("st_memaddr", memaddr[2], 32'h40);
            chk("st_memwdata", memwdata[2], 32'hDEAD_BEEF);
            chk("st_dready", {31'b0, dready[2]}, 32'd1);
         end
         adv();
      end
      dreq = 1'b0; dwe = 1'b0;
      idle(3);
      chk("st_one_strobe", we_cnt, 32'd1);

      // Reset in the middle of a fetch, then a load
      sel = 1;
      ireq = 1'b1; iaddr = 32'h500;
      mid();
      adv();
      rst = 1'b1;
      mid();
      chk("rs_iready_t1", {31'b0, iready[1]}, 32'd0);
      chk("rs_busy_t1", {31'b0, busy[1]}, 32'd1);
      adv();
      rst = 1'b0; ireq = 1'b0;
      mid();
      chk_all_zero(1);
      adv();
      t = cyc;
      dreq = 1'b1; dwe = 1'b0; daddr = 32'h80;
      sbq.push_back('{is_d: 1'b1, data: memf(32'h80), due: t + 2});
      for (int k = 0; k <= 2; k++) begin
         mid();
         if (k == 1) chk("rs_memaddr", memaddr[1], 32'h80);
         adv();
      end
      dreq = 1'b0;
      idle(2);

      // Back-to-back fetches at LATENCY=1
      sel = 0;
      t = cyc;
      ireq = 1'b1; iaddr = 32'h600;
      for (int k = 1; k < 8; k += 2)
         sbq.push_back('{is_d: 1'b0, data: memf(32'h600), due: t + k});
      for (int k = 0; k < 8; k++) begin
         mid();
         chk("bb_busy", {31'b0, busy[0]}, (k % 2 == 1) ? 32'd1 : 32'd0);
         chk("bb_iready", {31'b0, iready[0]}, (k % 2 == 1) ? 32'd1 : 32'd0);
         adv();
      end
      ireq = 1'b0;
      idle(2);

      // Idle for ten cycles
      sel = 1; we_cnt = 0;
      for (int k = 0; k < 10; k++) begin
         mid();
         for (int g = 0; g < 3; g++) begin
            chk("id_busy", {31'b0, busy[g]}, 32'd0);
            chk("id_stallif", {31'b0, stallif[g]}, 32'd0);
            chk("id_stallmem", {31'b0, stallmem[g]}, 32'd0);
            chk("id_memwe", {31'b0, memwe[g]}, 32'd0);
         end
         adv();
      end

      chk("sb_empty", sbq.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
